mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the native valid/ready CPU memory bus.
- Shares the SRAM/GPIO bus between the picorv32 core (master 0) and a second requester (master 1, loader/DMA).
- Grants are registered and held until the slave returns ready. Round-robin or fixed priority.
- A watchdog terminates hung slave accesses with an error word and a sticky error flag.

Parameters:
- FIXED_PRIORITY, 0: 0 = round-robin; 1 = master 0 always wins a tie.
- TIMEOUT_CYCLES, 64: maximum cycles in BUSY without s_ready before abort; legal range 2..255.
- ERR_RDATA, 32'hDEAD_BEEF: rdata returned to the owner on timeout.

Ports:
- clk  input  1  single clock.
- resetn  input  1  synchronous, active-low reset.
- m0_valid / m1_valid  input  1  master request; held high until the matching mN_ready.
- m0_instr / m1_instr  input  1  instruction-fetch qualifier.
- m0_addr / m1_addr  input  32  byte address.
- m0_wdata / m1_wdata  input  32  write data.
- m0_wstrb / m1_wstrb  input  4  byte write strobes; 0 = read.
- m0_ready / m1_ready  output  1  one-cycle completion pulse to the master.
- m0_rdata / m1_rdata  output  32  read data; valid only while the matching mN_ready is high.
- s_valid  output  1  request to slave.
- s_instr  output  1  muxed from owner.
- s_addr  output  32  muxed from owner.
- s_wdata  output  32  muxed from owner.
- s_wstrb  output  4  muxed from owner.
- s_ready  input  1  slave completion.
- s_rdata  input  32  slave read data.
- grant  output  2  one-hot current owner; 00 when idle.
- err_flag  output  1  sticky timeout indicator.
- err_addr  output  32  address of the first timed-out access.
- err_clr  input  1  clears err_flag and err_addr.

Behaviour:
- Interface: one clock, clk. Reset resetn is synchronous and active-low. All state updates happen on posedge clk.
- Reset values:
  - state IDLE, grant 00, s_valid 0, m0_ready 0, m1_ready 0.
  - err_flag 0, err_addr 0, watchdog counter 0.
  - Round-robin pointer = master 0 preferred.
- FSM states IDLE, BUSY, ERR.
- IDLE:
  - If no valid, stay.
  - If only one mN_valid, grant it and go to BUSY next edge.
  - If both valid: FIXED_PRIORITY=1 grants m0. FIXED_PRIORITY=0 grants the master not granted last.
  - The pointer updates on each grant.
- BUSY:
  - s_valid = owner's mN_valid. s_instr/addr/wdata/wstrb are combinationally muxed from the owner.
  - When s_ready=1: owner mN_ready=1 and mN_rdata=s_rdata in that same cycle; next state IDLE, grant 00.
  - Non-owner ready is 0 and its rdata is 0.
- Latency: with a registered-ready slave (ready one cycle after valid):
  - valid at cycle N, s_valid at N+1, mN_ready at N+2.
  - One mandatory IDLE cycle separates transactions (owner valid is still high in its ready cycle), so minimum issue interval is 3 cycles.
- Watchdog:
  - Counter clears on entry to BUSY and increments each BUSY cycle without s_ready.
  - When it reaches TIMEOUT_CYCLES-1 without s_ready, go to ERR.
- ERR (exactly one cycle):
  - s_valid=0; owner mN_ready=1 with mN_rdata=ERR_RDATA.
  - If err_flag was 0: set it and capture the owner address into err_addr. Later timeouts do not overwrite.
  - Next state IDLE.
- s_ready in the same cycle the counter expires: the completion wins and there is no error.
- Owner drops valid while in BUSY (protocol violation): return to IDLE next edge, no ready pulse, no error. s_valid follows the dropped valid.
- s_ready while IDLE or ERR: ignored, no ready to any master.
- err_clr:
  - Clears err_flag and err_addr next edge.
  - If it coincides with a new timeout, the set wins and the new address is captured.
- Reset mid-transaction: the next edge forces IDLE. In-flight access is dropped with no ready pulse; the master re-issues after reset.
- Unused-master inputs tied low must never be granted.

Test Plan:
- Single m0 read at addr 0x100, slave ready 1 cycle after s_valid with s_rdata 0x12345678 -> s_valid in cycle 1, m0_ready and m0_rdata=0x12345678 in cycle 2, grant 01 then 00; m1_ready stays 0.
- m0 and m1 both held valid continuously, round-robin -> grants alternate 01,10,01,10 with 3-cycle spacing. Same stimulus with FIXED_PRIORITY=1 -> m1 never granted while m0 stays valid.
- Slave never asserts ready on m1 write to 0x0010_0004, TIMEOUT_CYCLES=4 -> ERR after 4 BUSY cycles; m1_ready=1 with m1_rdata=0xDEADBEEF; err_flag=1, err_addr=0x0010_0004. A second timeout leaves err_addr unchanged; err_clr then zeroes both.
- s_ready asserted exactly on the watchdog-expiry cycle -> normal completion with s_rdata, err_flag stays 0.
- resetn low for one cycle while BUSY -> grant 00, s_valid 0, no ready pulse; a fresh m0 request after reset completes normally.
- Owner drops valid in BUSY before s_ready -> IDLE next cycle, no mN_ready, waiting other master granted on the following cycle.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Shared native valid/ready bus bundle for the two-master memory arbiter.
// The "master" modport is the arbiter's view: it takes both CPU-side requests
// and masters the shared slave bus. The "slave" modport is the surrounding
// system's view: it drives the requests and answers as the slave.
interface mem_bus_arbiter_if;
    logic        m0_valid;
    logic        m0_instr;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic [3:0]  m0_wstrb;
    logic        m0_ready;
    logic [31:0] m0_rdata;

    logic        m1_valid;
    logic        m1_instr;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic [3:0]  m1_wstrb;
    logic        m1_ready;
    logic [31:0] m1_rdata;

    logic        s_valid;
    logic        s_instr;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_ready;
    logic [31:0] s_rdata;

    logic [1:0]  grant;
    logic        err_flag;
    logic [31:0] err_addr;
    logic        err_clr;

    modport master (
        input  m0_valid, m0_instr, m0_addr, m0_wdata, m0_wstrb,
        input  m1_valid, m1_instr, m1_addr, m1_wdata, m1_wstrb,
        input  s_ready, s_rdata, err_clr,
        output m0_ready, m0_rdata, m1_ready, m1_rdata,
        output s_valid, s_instr, s_addr, s_wdata, s_wstrb,
        output grant, err_flag, err_addr
    );

    modport slave (
        output m0_valid, m0_instr, m0_addr, m0_wdata, m0_wstrb,
        output m1_valid, m1_instr, m1_addr, m1_wdata, m1_wstrb,
        output s_ready, s_rdata, err_clr,
        input  m0_ready, m0_rdata, m1_ready, m1_rdata,
        input  s_valid, s_instr, s_addr, s_wdata, s_wstrb,
        input  grant, err_flag, err_addr
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master, one-slave arbiter for the native valid/ready memory bus.
// Registered grant held until the slave completes; a watchdog aborts hung
// accesses with an error word and records the first failing address.
module mem_bus_arbiter #(
    parameter int unsigned FIXED_PRIORITY = 0,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input logic               clk,
    input logic               resetn,
    mem_bus_arbiter_if.master bus
);
    typedef enum logic [1:0] {StIdle, StBusy, StErr} state_e;

    localparam logic [7:0] WdogLast = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q;
    logic        owner_q;     // 0 = m0, 1 = m1
    logic [1:0]  grant_q;
    logic [7:0]  wdog_q;
    logic        rr_pref_q;   // round-robin: 1 = m1 preferred on a tie
    logic        err_flag_q;
    logic [31:0] err_addr_q;

    logic        owner_valid;
    logic [31:0] owner_addr;
    logic        pick_m1;
    logic        resp;
    logic [31:0] resp_data;

    // Owner-side request mux and arbitration decision.
    always_comb begin
        owner_valid = owner_q ? bus.m1_valid : bus.m0_valid;
        owner_addr  = owner_q ? bus.m1_addr  : bus.m0_addr;
        // m1 wins when alone, or on a tie in round-robin mode when it is preferred.
        pick_m1 = bus.m1_valid &&
                  (!bus.m0_valid || ((FIXED_PRIORITY == 0) && rr_pref_q));
    end

    // Arbitration FSM, watchdog and sticky error capture.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= StIdle;
            owner_q    <= 1'b0;
            grant_q    <= 2'b00;
            wdog_q     <= 8'd0;
            rr_pref_q  <= 1'b0;
            err_flag_q <= 1'b0;
            err_addr_q <= 32'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.m0_valid || bus.m1_valid) begin
                        owner_q   <= pick_m1;
                        grant_q   <= pick_m1 ? 2'b10 : 2'b01;
                        rr_pref_q <= !pick_m1;
                        wdog_q    <= 8'd0;
                        state_q   <= StBusy;
                    end
                end
                StBusy: begin
                    // A dropped request is abandoned silently; completion beats expiry.
                    if (!owner_valid || bus.s_ready) begin
                        state_q <= StIdle;
                        grant_q <= 2'b00;
                    end else if (wdog_q == WdogLast) begin
                        state_q <= StErr;
                    end else begin
                        wdog_q <= wdog_q + 8'd1;
                    end
                end
                StErr: begin
                    state_q <= StIdle;
                    grant_q <= 2'b00;
                end
                default: begin
                    state_q <= StIdle;
                    grant_q <= 2'b00;
                end
            endcase

            // Only the first timeout is recorded; a coincident clear lets a new one in.
            if ((state_q == StErr) && (!err_flag_q || bus.err_clr)) begin
                err_flag_q <= 1'b1;
                err_addr_q <= owner_addr;
            end else if (bus.err_clr) begin
                err_flag_q <= 1'b0;
                err_addr_q <= 32'd0;
            end
        end
    end

    // Slave-side mux and completion steering back to the owner.
    always_comb begin
        bus.s_valid = (state_q == StBusy) && owner_valid;
        bus.s_instr = owner_q ? bus.m1_instr : bus.m0_instr;
        bus.s_addr  = owner_addr;
        bus.s_wdata = owner_q ? bus.m1_wdata : bus.m0_wdata;
        bus.s_wstrb = owner_q ? bus.m1_wstrb : bus.m0_wstrb;

        resp      = ((state_q == StBusy) && owner_valid && bus.s_ready) || (state_q == StErr);
        resp_data = (state_q == StErr) ? ERR_RDATA : bus.s_rdata;

        bus.m0_ready = resp && !owner_q;
        bus.m1_ready = resp && owner_q;
        bus.m0_rdata = bus.m0_ready ? resp_data : 32'd0;
        bus.m1_rdata = bus.m1_ready ? resp_data : 32'd0;

        bus.grant    = grant_q;
        bus.err_flag = err_flag_q;
        bus.err_addr = err_addr_q;
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: a round-robin and a fixed-priority instance run side by side,
// each compared every cycle against a transaction-level reference model.
module tb_mem_bus_arbiter;
    localparam int unsigned Timeout = 4;
    localparam logic [31:0] ErrData = 32'hDEAD_BEEF;

    logic clk;
    logic resetn;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Index k: 0 = round-robin instance, 1 = fixed-priority instance; j = master.
    logic [1:0][1:0]       mv, mi;
    logic [1:0][1:0][31:0] ma, mw;
    logic [1:0][1:0][3:0]  ms;
    logic [1:0]            sr, ec;
    logic [1:0][31:0]      sd;

    logic [1:0][1:0]       o_rdy;
    logic [1:0][1:0][31:0] o_rd;
    logic [1:0]            o_sv, o_si, o_ef;
    logic [1:0][31:0]      o_sa, o_sw, o_ea;
    logic [1:0][3:0]       o_ss;
    logic [1:0][1:0]       o_gr;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_bus_arbiter_if bus ();
        mem_bus_arbiter #(
            .FIXED_PRIORITY(g),
            .TIMEOUT_CYCLES(Timeout),
            .ERR_RDATA     (ErrData)
        ) dut (
            .clk   (clk),
            .resetn(resetn),
            .bus   (bus)
        );
        assign bus.m0_valid = mv[g][0];
        assign bus.m0_instr = mi[g][0];
        assign bus.m0_addr  = ma[g][0];
        assign bus.m0_wdata = mw[g][0];
        assign bus.m0_wstrb = ms[g][0];
        assign bus.m1_valid = mv[g][1];
        assign bus.m1_instr = mi[g][1];
        assign bus.m1_addr  = ma[g][1];
        assign bus.m1_wdata = mw[g][1];
        assign bus.m1_wstrb = ms[g][1];
        assign bus.s_ready  = sr[g];
        assign bus.s_rdata  = sd[g];
        assign bus.err_clr  = ec[g];
        assign o_rdy[g]     = {bus.m1_ready, bus.m0_ready};
        assign o_rd[g][0]   = bus.m0_rdata;
        assign o_rd[g][1]   = bus.m1_rdata;
        assign o_sv[g]      = bus.s_valid;
        assign o_si[g]      = bus.s_instr;
        assign o_sa[g]      = bus.s_addr;
        assign o_sw[g]      = bus.s_wdata;
        assign o_ss[g]      = bus.s_wstrb;
        assign o_gr[g]      = bus.grant;
        assign o_ef[g]      = bus.err_flag;
        assign o_ea[g]      = bus.err_addr;
    end

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Reference model: who owns the bus, how long it has waited, and the sticky error.
    int          own   [2];   // -1 = nobody
    int          age   [2];   // busy cycles spent without a slave response
    bit          ierr  [2];   // abort cycle pending for the owner
    bit          pref1 [2];   // m0 was granted last
    bit          eflag [2];
    logic [31:0] eaddr [2];

    // Environment controls and values sampled at the last negedge.
    bit          auto_m    = 1'b0;
    bit          hold_both = 1'b0;
    bit          rand_clr  = 1'b0;
    int          slave_mode = 0;  // 0 manual, 1 registered ready, 2 random, 3 never
    logic [31:0] slave_data = 32'd0;
    logic [1:0][1:0]       sn_rdy;
    logic [1:0][1:0][31:0] sn_rd;
    logic [1:0]            sn_sv, sn_ef;
    logic [1:0][31:0]      sn_sa, sn_ea;
    logic [1:0][1:0]       sn_gr;

    task automatic chk(input string tag, input int k, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d observed %h expected %h", tag, k, obs, exp);
        end
    endtask

    task automatic model_check(input int k);
        logic [1:0]  e_rdy;
        logic [31:0] e_data;
        logic [31:0] e_gr;
        logic        e_sv;
        logic        oj;
        e_rdy  = 2'b00;
        e_data = 32'd0;
        e_gr   = 32'd0;
        e_sv   = 1'b0;
        oj     = (own[k] == 1);
        if (own[k] >= 0) begin
            e_gr = oj ? 32'd2 : 32'd1;
            if (ierr[k]) begin
                e_rdy[oj] = 1'b1;
                e_data    = ErrData;
            end else if (mv[k][oj]) begin
                e_sv = 1'b1;
                if (sr[k]) begin
                    e_rdy[oj] = 1'b1;
                    e_data    = sd[k];
                end
            end
        end
        chk("grant", k, 32'(o_gr[k]), e_gr);
        chk("s_valid", k, 32'(o_sv[k]), 32'(e_sv));
        chk("m0_ready", k, 32'(o_rdy[k][0]), 32'(e_rdy[0]));
        chk("m1_ready", k, 32'(o_rdy[k][1]), 32'(e_rdy[1]));
        chk("m0_rdata", k, o_rd[k][0], e_rdy[0] ? e_data : 32'd0);
        chk("m1_rdata", k, o_rd[k][1], e_rdy[1] ? e_data : 32'd0);
        chk("err_flag", k, 32'(o_ef[k]), 32'(eflag[k]));
        chk("err_addr", k, o_ea[k], eaddr[k]);
        if (e_sv) begin
            chk("s_addr", k, o_sa[k], ma[k][oj]);
            chk("s_wdata", k, o_sw[k], mw[k][oj]);
            chk("s_wstrb", k, 32'(o_ss[k]), 32'(ms[k][oj]));
            chk("s_instr", k, 32'(o_si[k]), 32'(mi[k][oj]));
        end
        sn_rdy[k] = o_rdy[k];
        sn_rd[k]  = o_rd[k];
        sn_sv[k]  = o_sv[k];
        sn_sa[k]  = o_sa[k];
        sn_gr[k]  = o_gr[k];
        sn_ef[k]  = o_ef[k];
        sn_ea[k]  = o_ea[k];
    endtask

    task automatic model_update(input int k);
        logic oj;
        oj = (own[k] == 1);
        if (!resetn) begin
            own[k] = -1; age[k] = 0; ierr[k] = 1'b0; pref1[k] = 1'b0;
            eflag[k] = 1'b0; eaddr[k] = 32'd0;
        end else if (own[k] >= 0 && ierr[k]) begin
            if (!eflag[k] || ec[k]) begin
                eflag[k] = 1'b1;
                eaddr[k] = ma[k][oj];
            end
            own[k]  = -1;
            ierr[k] = 1'b0;
        end else begin
            if (ec[k]) begin
                eflag[k] = 1'b0;
                eaddr[k] = 32'd0;
            end
            if (own[k] < 0) begin
                if (mv[k][0] && mv[k][1]) own[k] = (k == 1) ? 0 : (pref1[k] ? 1 : 0);
                else if (mv[k][0]) own[k] = 0;
                else if (mv[k][1]) own[k] = 1;
                if (own[k] >= 0) begin
                    pref1[k] = (own[k] == 0);
                    age[k]   = 0;
                end
            end else if (!mv[k][oj] || sr[k]) begin
                own[k] = -1;
            end else begin
                age[k]++;
                if (age[k] == int'(Timeout)) ierr[k] = 1'b1;
            end
        end
    endtask

    task automatic new_payload(input int k, input int j);
        ma[k][j] = $urandom;
        mw[k][j] = $urandom;
        ms[k][j] = 4'($urandom_range(15));
        mi[k][j] = 1'($urandom_range(1));
    endtask

    task automatic env_drive();
        for (int k = 0; k < 2; k++) begin
            if (auto_m || hold_both) begin
                for (int j = 0; j < 2; j++) begin
                    if (hold_both) begin
                        mv[k][j] = 1'b1;
                        if (sn_rdy[k][j]) new_payload(k, j);
                    end else if (mv[k][j]) begin
                        if (sn_rdy[k][j] || $urandom_range(63) == 0) mv[k][j] = 1'b0;
                    end else if ($urandom_range(3) == 0) begin
                        mv[k][j] = 1'b1;
                        new_payload(k, j);
                    end
                end
            end
            case (slave_mode)
                1: begin sr[k] = sn_sv[k] && !sr[k]; sd[k] = slave_data; end
                2: begin sr[k] = ($urandom_range(2) == 0); sd[k] = $urandom; end
                3: sr[k] = 1'b0;
                default: ;
            endcase
            if (rand_clr) ec[k] = ($urandom_range(15) == 0);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (cmp_en) for (int k = 0; k < 2; k++) model_check(k);
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_update(k);
        #1;
        env_drive();
    endtask

    initial begin
        resetn = 1'b0;
        mv = '0; mi = '0; ma = '0; mw = '0; ms = '0; sr = '0; ec = '0; sd = '0;
        tick();
        cmp_en = 1'b1;
        tick();
        resetn = 1'b1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_grant", k, 32'(sn_gr[k]), 32'd0);
            chk("rst_s_valid", k, 32'(sn_sv[k]), 32'd0);
            chk("rst_ready", k, 32'(sn_rdy[k]), 32'd0);
            chk("rst_err_flag", k, 32'(sn_ef[k]), 32'd0);
        end

        // Single m0 read through a registered-ready slave.
        slave_mode = 1;
        slave_data = 32'h1234_5678;
        for (int k = 0; k < 2; k++) begin
            mv[k][0] = 1'b1; ma[k][0] = 32'h100; ms[k][0] = 4'h0; mi[k][0] = 1'b0;
        end
        tick();
        tick();
        for (int k = 0; k < 2; k++) begin
            chk("t1_grant", k, 32'(sn_gr[k]), 32'd1);
            chk("t1_s_valid", k, 32'(sn_sv[k]), 32'd1);
            chk("t1_s_addr", k, sn_sa[k], 32'h100);
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            chk("t1_m0_ready", k, 32'(sn_rdy[k][0]), 32'd1);
            chk("t1_m0_rdata", k, sn_rd[k][0], 32'h1234_5678);
            chk("t1_m1_ready", k, 32'(sn_rdy[k][1]), 32'd0);
            mv[k][0] = 1'b0;
        end
        tick();
        for (int k = 0; k < 2; k++) chk("t1_idle_grant", k, 32'(sn_gr[k]), 32'd0);

        // Both masters held valid: alternation vs fixed priority.
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        hold_both = 1'b1;
        mv = '1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("t2_rr_grant", 0, 32'(sn_gr[0]),
                (i % 3 == 0) ? 32'd0 : (((i / 3) % 2 == 0) ? 32'd1 : 32'd2));
            chk("t2_fp_grant", 1, 32'(sn_gr[1]), (i % 3 == 0) ? 32'd0 : 32'd1);
        end
        hold_both = 1'b0;
        mv = '0;
        slave_mode = 3;
        sr = '0;
        repeat (3) tick();

        // Hung slave on an m1 write, then a second timeout, then clear.
        for (int k = 0; k < 2; k++) begin
            mv[k][1] = 1'b1; ma[k][1] = 32'h0010_0004; ms[k][1] = 4'hF; mw[k][1] = 32'h55AA_1234;
        end
        repeat (6) tick();
        for (int k = 0; k < 2; k++) begin
            chk("t3_m1_ready", k, 32'(sn_rdy[k][1]), 32'd1);
            chk("t3_m1_rdata", k, sn_rd[k][1], 32'hDEAD_BEEF);
            chk("t3_err_s_valid", k, 32'(sn_sv[k]), 32'd0);
            mv[k][1] = 1'b0;
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            chk("t3_err_flag", k, 32'(sn_ef[k]), 32'd1);
            chk("t3_err_addr", k, sn_ea[k], 32'h0010_0004);
            mv[k][0] = 1'b1; ma[k][0] = 32'h200; ms[k][0] = 4'h0;
        end
        repeat (6) tick();
        for (int k = 0; k < 2; k++) mv[k][0] = 1'b0;
        tick();
        for (int k = 0; k < 2; k++) begin
            chk("t3_second_flag", k, 32'(sn_ef[k]), 32'd1);
            chk("t3_second_addr", k, sn_ea[k], 32'h0010_0004);
        end
        ec = '1;
        tick();
        ec = '0;
        tick();
        for (int k = 0; k < 2; k++) begin
            chk("t3_clr_flag", k, 32'(sn_ef[k]), 32'd0);
            chk("t3_clr_addr", k, sn_ea[k], 32'd0);
        end

        // Slave answers on the very cycle the watchdog would expire.
        slave_mode = 0;
        for (int k = 0; k < 2; k++) begin
            mv[k][0] = 1'b1; ma[k][0] = 32'h300; sd[k] = 32'hCAFE_0001;
        end
        repeat (4) tick();
        sr = '1;
        tick();
        for (int k = 0; k < 2; k++) begin
            chk("t4_m0_ready", k, 32'(sn_rdy[k][0]), 32'd1);
            chk("t4_m0_rdata", k, sn_rd[k][0], 32'hCAFE_0001);
            mv[k][0] = 1'b0;
        end
        sr = '0;
        tick();
        for (int k = 0; k < 2; k++) chk("t4_no_err", k, 32'(sn_ef[k]), 32'd0);

        // Reset while busy, then the re-issued request completes.
        for (int k = 0; k < 2; k++) begin
            mv[k][0] = 1'b1; ma[k][0] = 32'h400;
        end
        tick();
        tick();
        for (int k = 0; k < 2; k++) chk("t5_busy_grant", k, 32'(sn_gr[k]), 32'd1);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            chk("t5_rst_grant", k, 32'(sn_gr[k]), 32'd0);
            chk("t5_rst_s_valid", k, 32'(sn_sv[k]), 32'd0);
            chk("t5_rst_ready", k, 32'(sn_rdy[k][0]), 32'd0);
        end
        slave_mode = 1;
        slave_data = 32'h0BAD_F00D;
        tick();
        tick();
        for (int k = 0; k < 2; k++) begin
            chk("t5_m0_ready", k, 32'(sn_rdy[k][0]), 32'd1);
            chk("t5_m0_rdata", k, sn_rd[k][0], 32'h0BAD_F00D);
            mv[k][0] = 1'b0;
        end
        slave_mode = 0;
        sr = '0;
        tick();

        // Owner abandons its request while m1 waits.
        for (int k = 0; k < 2; k++) begin
            mv[k][0] = 1'b1; ma[k][0] = 32'h500;
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            mv[k][1] = 1'b1; ma[k][1] = 32'h600;
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            chk("t6_grant_m0", k, 32'(sn_gr[k]), 32'd1);
            mv[k][0] = 1'b0;
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            chk("t6_drop_s_valid", k, 32'(sn_sv[k]), 32'd0);
            chk("t6_drop_ready", k, 32'(sn_rdy[k]), 32'd0);
        end
        tick();
        for (int k = 0; k < 2; k++) chk("t6_idle_grant", k, 32'(sn_gr[k]), 32'd0);
        tick();
        for (int k = 0; k < 2; k++) begin
            chk("t6_grant_m1", k, 32'(sn_gr[k]), 32'd2);
            mv[k][1] = 1'b0;
        end
        tick();

        // Randomized traffic against the model.
        auto_m   = 1'b1;
        rand_clr = 1'b1;
        for (int b = 0; b < 40; b++) begin
            slave_mode = 1 + int'($urandom_range(2));
            repeat (50) begin
                resetn = ($urandom_range(149) != 0);
                tick();
            end
        end
        resetn = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
